// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and defaults for the matrix-multiply accelerator:
//               controller state encoding, default dimensions and widths, and
//               a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int c_DEF_M   = 4;
    localparam int c_DEF_K   = 4;
    localparam int c_DEF_N   = 4;
    localparam int c_DEF_DWI = 8;
    localparam int c_DEF_DWF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Index width that never collapses to zero bits for a dimension of 1.
    function automatic int safe_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_pe.sv
`default_nettype none
// ============================================================================
// Module      : mac_pe
// Description : Two-stage multiply/accumulate element. Stage 1 registers the
//               unsigned operand product; stage 2 folds it into the
//               accumulator (restarting on clear) and flags the final term of
//               each dot product. Build macro MAC_SATURATE_EN selects
//               clamping at all-ones instead of modulo wrap-around.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_pe
    import mac_pkg::*;
#(
    parameter int DATA_WIDTH_INITIAL = c_DEF_DWI,
    parameter int DATA_WIDTH_FINAL   = c_DEF_DWF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          i_valid,
    input  logic                          i_clear,
    input  logic                          i_last,
    input  logic [DATA_WIDTH_INITIAL-1:0] i_a,
    input  logic [DATA_WIDTH_INITIAL-1:0] i_b,
    output logic [DATA_WIDTH_FINAL-1:0]   o_acc,
    output logic                          o_res_valid
);

    localparam int DWF = DATA_WIDTH_FINAL;

    logic [DWF-1:0] w_prod;
    logic [DWF-1:0] r_prod;
    logic           r_s1_valid;
    logic           r_s1_clear;
    logic           r_s1_last;
    logic [DWF-1:0] r_acc;
    logic           r_res_valid;
    logic [DWF-1:0] w_base;
    logic [DWF-1:0] w_acc_next;

    assign w_prod = DWF'(i_a) * DWF'(i_b);
    assign w_base = r_s1_clear ? '0 : r_acc;

`ifdef MAC_SATURATE_EN
    logic [DWF:0] w_sum;
    assign w_sum      = {1'b0, w_base} + {1'b0, r_prod};
    // A carry out means the true sum exceeds the range: pin at all-ones.
    assign w_acc_next = w_sum[DWF] ? '1 : w_sum[DWF-1:0];
`else
    assign w_acc_next = w_base + r_prod;
`endif

    // Stage 1: register the product together with its clear/last tags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_prod     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_clear <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_prod     <= w_prod;
            r_s1_valid <= i_valid;
            r_s1_clear <= i_clear;
            r_s1_last  <= i_last;
        end
    end

    // Stage 2: accumulate and mark the cycle the dot product is complete.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            if (r_s1_valid) begin
                r_acc <= w_acc_next;
            end
            r_res_valid <= r_s1_valid & r_s1_last;
        end
    end

    assign o_acc       = r_acc;
    assign o_res_valid = r_res_valid;

endmodule
`default_nettype wire

// File: rtl/mac_top.sv
`default_nettype none
// ============================================================================
// Module      : mac_top
// Description : Matrix-multiply accelerator C = A * B (unsigned operands).
//               Host loads A and B in one write beat, a pipelined MAC walks
//               (m,n,k) with k innermost, and C is returned in one read beat.
//               Build macro MAC_SATURATE_EN makes accumulation saturate.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_top
    import mac_pkg::*;
#(
    parameter int param_M            = c_DEF_M,
    parameter int param_K            = c_DEF_K,
    parameter int param_N            = c_DEF_N,
    parameter int DATA_WIDTH_INITIAL = c_DEF_DWI,
    parameter int DATA_WIDTH_FINAL   = c_DEF_DWF
) (
    input  logic                                                  clk,
    input  logic                                                  rstn,
    input  logic                                                  host2block_val,
    input  logic                                                  block2host_rdy,
    input  logic [param_M*param_K-1:0][DATA_WIDTH_INITIAL-1:0]    a_data_in_ext,
    input  logic [param_K*param_N-1:0][DATA_WIDTH_INITIAL-1:0]    b_data_in_ext,
    input  logic                                                  a_b_we_ext,
    input  logic                                                  c_re_ext,
    output logic [param_M*param_N-1:0][DATA_WIDTH_FINAL-1:0]      c_data_out_ext,
    output logic                                                  mac_done,
    output logic                                                  block2host_val,
    output logic                                                  host2block_rdy
);

    localparam int MW = safe_clog2(param_M);
    localparam int KW = safe_clog2(param_K);
    localparam int NW = safe_clog2(param_N);
    localparam int AW = safe_clog2(param_M * param_K);
    localparam int BW = safe_clog2(param_K * param_N);
    localparam int CW = safe_clog2(param_M * param_N);

    localparam logic [MW-1:0] c_M_LAST  = MW'(param_M - 1);
    localparam logic [KW-1:0] c_K_LAST  = KW'(param_K - 1);
    localparam logic [NW-1:0] c_N_LAST  = NW'(param_N - 1);
    localparam logic [CW-1:0] c_WR_LAST = CW'(param_M * param_N - 1);

    state_t r_state;
    state_t w_state_next;

    logic [param_M*param_K-1:0][DATA_WIDTH_INITIAL-1:0] r_a;
    logic [param_K*param_N-1:0][DATA_WIDTH_INITIAL-1:0] r_b;
    logic [param_M*param_N-1:0][DATA_WIDTH_FINAL-1:0]   r_c;
    logic [param_M*param_N-1:0][DATA_WIDTH_FINAL-1:0]   r_c_out;

    logic [MW-1:0] r_m;
    logic [NW-1:0] r_n;
    logic [KW-1:0] r_k;
    logic          r_issue_done;
    logic [CW-1:0] r_wr_idx;

    logic                        w_load;
    logic                        w_read;
    logic                        w_issue;
    logic                        w_last_issue;
    logic                        w_last_write;
    logic [AW-1:0]               w_a_idx;
    logic [BW-1:0]               w_b_idx;
    logic [DATA_WIDTH_FINAL-1:0] w_acc;
    logic                        w_res_valid;

    assign w_load       = (r_state == LOAD) && a_b_we_ext;
    assign w_read       = (r_state == DONE) && block2host_rdy && c_re_ext;
    assign w_issue      = (r_state == COMPUTE) && !r_issue_done;
    assign w_last_issue = (r_m == c_M_LAST) && (r_n == c_N_LAST) && (r_k == c_K_LAST);
    assign w_last_write = w_res_valid && (r_wr_idx == c_WR_LAST);

    // A is stored row-major (m*K+k); B is stored transposed (n*K+k).
    assign w_a_idx = AW'(r_m) * AW'(param_K) + AW'(r_k);
    assign w_b_idx = BW'(r_n) * BW'(param_K) + BW'(r_k);

    // Controller state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; handshake outputs depend only on the registered state.
    always_comb begin
        w_state_next   = r_state;
        host2block_rdy = 1'b0;
        mac_done       = 1'b0;
        block2host_val = 1'b0;
        case (r_state)
            IDLE: begin
                if (host2block_val) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                host2block_rdy = 1'b1;
                if (a_b_we_ext) begin
                    w_state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (w_last_write) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                mac_done       = 1'b1;
                block2host_val = 1'b1;
                if (block2host_rdy && c_re_ext) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand capture during LOAD.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a <= '0;
            r_b <= '0;
        end else if (w_load) begin
            r_a <= a_data_in_ext;
            r_b <= b_data_in_ext;
        end
    end

    // Issue counters: k innermost, then n, then m; one product per cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_m          <= '0;
            r_n          <= '0;
            r_k          <= '0;
            r_issue_done <= 1'b0;
        end else if (w_load) begin
            r_m          <= '0;
            r_n          <= '0;
            r_k          <= '0;
            r_issue_done <= 1'b0;
        end else if (w_issue) begin
            if (w_last_issue) begin
                r_issue_done <= 1'b1;
            end
            if (r_k == c_K_LAST) begin
                r_k <= '0;
                if (r_n == c_N_LAST) begin
                    r_n <= '0;
                    r_m <= r_m + MW'(1);
                end else begin
                    r_n <= r_n + NW'(1);
                end
            end else begin
                r_k <= r_k + KW'(1);
            end
        end
    end

    // Results retire in the same row-major order they were issued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_c      <= '0;
            r_wr_idx <= '0;
        end else if (w_load) begin
            r_wr_idx <= '0;
        end else if ((r_state == COMPUTE) && w_res_valid) begin
            r_c[r_wr_idx] <= w_acc;
            r_wr_idx      <= r_wr_idx + CW'(1);
        end
    end

    // Output register: updated only by an accepted read beat in DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_c_out <= '0;
        end else if (w_read) begin
            r_c_out <= r_c;
        end
    end

    assign c_data_out_ext = r_c_out;

    mac_pe #(
        .DATA_WIDTH_INITIAL (DATA_WIDTH_INITIAL),
        .DATA_WIDTH_FINAL   (DATA_WIDTH_FINAL)
    ) u_pe (
        .clk         (clk),
        .rstn        (rstn),
        .i_valid     (w_issue),
        .i_clear     (r_k == '0),
        .i_last      (r_k == c_K_LAST),
        .i_a         (r_a[w_a_idx]),
        .i_b         (r_b[w_b_idx]),
        .o_acc       (w_acc),
        .o_res_valid (w_res_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_mac_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_top
// Description : Self-checking bench for mac_top with a matrix-level reference
//               model. Honors MAC_SATURATE_EN for the expected arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_top;

    localparam int M   = 4;
    localparam int K   = 4;
    localparam int N   = 4;
    localparam int DWI = 8;
    localparam int DWF = 16;
    localparam int LAT = M * N * K + 2;

    typedef logic [M*K-1:0][DWI-1:0] amat_t;
    typedef logic [K*N-1:0][DWI-1:0] bmat_t;
    typedef logic [M*N-1:0][DWF-1:0] cmat_t;

    logic  clk = 1'b0;
    logic  rstn;
    logic  host2block_val;
    logic  block2host_rdy;
    amat_t a_data_in_ext;
    bmat_t b_data_in_ext;
    logic  a_b_we_ext;
    logic  c_re_ext;
    cmat_t c_data_out_ext;
    logic  mac_done;
    logic  block2host_val;
    logic  host2block_rdy;

    int    checks = 0;
    int    errors = 0;
    cmat_t last_c_exp;

    always #5 clk = ~clk;

    mac_top dut (
        .clk            (clk),
        .rstn           (rstn),
        .host2block_val (host2block_val),
        .block2host_rdy (block2host_rdy),
        .a_data_in_ext  (a_data_in_ext),
        .b_data_in_ext  (b_data_in_ext),
        .a_b_we_ext     (a_b_we_ext),
        .c_re_ext       (c_re_ext),
        .c_data_out_ext (c_data_out_ext),
        .mac_done       (mac_done),
        .block2host_val (block2host_val),
        .host2block_rdy (host2block_rdy)
    );

    // Reference: plain dot products over the matrices, then wrap or clamp.
    function automatic cmat_t model(input amat_t a, input bmat_t b);
        cmat_t  c;
        longint s;
        for (int m = 0; m < M; m++) begin
            for (int n = 0; n < N; n++) begin
                s = 0;
                for (int k = 0; k < K; k++) begin
                    s += longint'(a[m*K+k]) * longint'(b[n*K+k]);
                end
`ifdef MAC_SATURATE_EN
                c[m*N+n] = (s > 65535) ? 16'hFFFF : DWF'(s);
`else
                c[m*N+n] = DWF'(s % 65536);
`endif
            end
        end
        return c;
    endfunction

    function automatic amat_t ramp_a();
        amat_t a;
        for (int i = 0; i < M*K; i++) a[i] = DWI'(i);
        return a;
    endfunction

    // B[k][n] = k*N+n, delivered transposed (element n*K+k).
    function automatic bmat_t ramp_b();
        bmat_t b;
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
                b[n*K+k] = DWI'(k*N+n);
        return b;
    endfunction

    function automatic amat_t rand_a();
        amat_t a;
        for (int i = 0; i < M*K; i++) a[i] = DWI'($urandom_range(0, 255));
        return a;
    endfunction

    function automatic bmat_t rand_b();
        bmat_t b;
        for (int i = 0; i < K*N; i++) b[i] = DWI'($urandom_range(0, 255));
        return b;
    endfunction

    // Start from IDLE, load, count cycles from COMPUTE entry to mac_done.
    task automatic do_op(input amat_t a, input bmat_t b, output int lat, output bit rdy_seen);
        host2block_val = 1'b1;
        @(posedge clk); #1;
        host2block_val = 1'b0;
        a_data_in_ext  = a;
        b_data_in_ext  = b;
        a_b_we_ext     = 1'b1;
        @(posedge clk); #1;
        a_b_we_ext = 1'b0;
        lat        = 0;
        rdy_seen   = 1'b0;
        while (!mac_done && lat < 500) begin
            if (host2block_rdy) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_read();
        block2host_rdy = 1'b1;
        c_re_ext       = 1'b1;
        @(posedge clk); #1;
        block2host_rdy = 1'b0;
        c_re_ext       = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        host2block_val = 1'b0; block2host_rdy = 1'b0;
        a_b_we_ext = 1'b0; c_re_ext = 1'b0;
        a_data_in_ext = '0; b_data_in_ext = '0;
        #12;
        checks++;
        if ({mac_done, block2host_val, host2block_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000", {mac_done, block2host_val, host2block_rdy});
        end
        checks++;
        if (c_data_out_ext !== '0) begin
            errors++;
            $display("FAIL reset_cout: got %h expected 0", c_data_out_ext);
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({mac_done, block2host_val, host2block_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL idle_flags: got %b expected 000", {mac_done, block2host_val, host2block_rdy});
        end
        last_c_exp = '0;
    endtask

    task automatic test_ramp();
        int    lat;
        bit    rs;
        cmat_t exp_c;
        exp_c = model(ramp_a(), ramp_b());
        do_op(ramp_a(), ramp_b(), lat, rs);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL ramp_latency: got %0d expected %0d", lat, LAT);
        end
        checks++;
        if (rs !== 1'b0) begin
            errors++;
            $display("FAIL rdy_in_compute: got %0d expected 0", rs);
        end
        checks++;
        if ({mac_done, block2host_val, host2block_rdy} !== 3'b110) begin
            errors++;
            $display("FAIL done_flags: got %b expected 110", {mac_done, block2host_val, host2block_rdy});
        end
        do_read();
        last_c_exp = exp_c;
        checks++;
        if (c_data_out_ext !== exp_c) begin
            errors++;
            $display("FAIL ramp_c: got %h expected %h", c_data_out_ext, exp_c);
        end
        checks++;
        if (c_data_out_ext[0] !== 16'd56 || c_data_out_ext[1] !== 16'd62 || c_data_out_ext[15] !== 16'd506) begin
            errors++;
            $display("FAIL ramp_corners: got %0d %0d %0d expected 56 62 506",
                     c_data_out_ext[0], c_data_out_ext[1], c_data_out_ext[15]);
        end
        checks++;
        if ({mac_done, block2host_val, host2block_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL after_read_flags: got %b expected 000", {mac_done, block2host_val, host2block_rdy});
        end
    endtask

    task automatic test_random();
        int    lat;
        bit    rs;
        amat_t a;
        bmat_t b;
        for (int it = 0; it < 5; it++) begin
            a = rand_a();
            b = rand_b();
            do_op(a, b, lat, rs);
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, lat, LAT);
            end
            do_read();
            last_c_exp = model(a, b);
            checks++;
            if (c_data_out_ext !== last_c_exp) begin
                errors++;
                $display("FAIL rand_c[%0d]: got %h expected %h", it, c_data_out_ext, last_c_exp);
            end
        end
    endtask

    task automatic test_overflow();
        int    lat;
        bit    rs;
        amat_t a;
        bmat_t b;
        logic [DWF-1:0] corner;
        a = '1;
        b = '1;
`ifdef MAC_SATURATE_EN
        corner = 16'd65535;
`else
        corner = 16'd63492;
`endif
        do_op(a, b, lat, rs);
        do_read();
        last_c_exp = model(a, b);
        checks++;
        if (c_data_out_ext !== last_c_exp) begin
            errors++;
            $display("FAIL overflow_c: got %h expected %h", c_data_out_ext, last_c_exp);
        end
        checks++;
        if (c_data_out_ext[5] !== corner) begin
            errors++;
            $display("FAIL overflow_elem: got %0d expected %0d", c_data_out_ext[5], corner);
        end
    endtask

    task automatic test_load_wait();
        amat_t a;
        bmat_t b;
        int    cnt;
        a = rand_a();
        b = rand_b();
        // Write and read strobes in IDLE must do nothing.
        a_data_in_ext = rand_a(); b_data_in_ext = rand_b();
        a_b_we_ext = 1'b1; c_re_ext = 1'b1; block2host_rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        a_b_we_ext = 1'b0; c_re_ext = 1'b0; block2host_rdy = 1'b0;
        checks++;
        if ({mac_done, host2block_rdy} !== 2'b00 || c_data_out_ext !== last_c_exp) begin
            errors++;
            $display("FAIL idle_strobes: flags %b cout %h expected 00 %h",
                     {mac_done, host2block_rdy}, c_data_out_ext, last_c_exp);
        end
        host2block_val = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (host2block_rdy !== 1'b1 || mac_done !== 1'b0) begin
                errors++;
                $display("FAIL load_hold[%0d]: rdy %b done %b expected 1 0", i, host2block_rdy, mac_done);
            end
            @(posedge clk); #1;
        end
        a_data_in_ext = a; b_data_in_ext = b; a_b_we_ext = 1'b1;
        @(posedge clk); #1;
        a_b_we_ext = 1'b0; host2block_val = 1'b0;
        cnt = 0;
        while (!mac_done && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        checks++;
        if (cnt !== LAT) begin
            errors++;
            $display("FAIL load_wait_latency: got %0d expected %0d", cnt, LAT);
        end
        // A write strobe in DONE must not disturb the stored result.
        a_data_in_ext = rand_a(); b_data_in_ext = rand_b(); a_b_we_ext = 1'b1;
        @(posedge clk); #1;
        a_b_we_ext = 1'b0;
        checks++;
        if (mac_done !== 1'b1) begin
            errors++;
            $display("FAIL done_we_ignored: done %b expected 1", mac_done);
        end
        do_read();
        last_c_exp = model(a, b);
        checks++;
        if (c_data_out_ext !== last_c_exp) begin
            errors++;
            $display("FAIL load_wait_c: got %h expected %h", c_data_out_ext, last_c_exp);
        end
    endtask

    task automatic test_read_handshake();
        int    lat;
        bit    rs;
        amat_t a;
        bmat_t b;
        a = rand_a();
        b = rand_b();
        do_op(a, b, lat, rs);
        c_re_ext = 1'b1; block2host_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mac_done !== 1'b1 || block2host_val !== 1'b1 || c_data_out_ext !== last_c_exp) begin
                errors++;
                $display("FAIL read_stall[%0d]: done %b val %b cout %h expected 1 1 %h",
                         i, mac_done, block2host_val, c_data_out_ext, last_c_exp);
            end
        end
        c_re_ext = 1'b0; block2host_rdy = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mac_done !== 1'b1 || c_data_out_ext !== last_c_exp) begin
            errors++;
            $display("FAIL rdy_only: done %b cout %h expected 1 %h", mac_done, c_data_out_ext, last_c_exp);
        end
        block2host_rdy = 1'b0;
        do_read();
        last_c_exp = model(a, b);
        checks++;
        if (c_data_out_ext !== last_c_exp || mac_done !== 1'b0) begin
            errors++;
            $display("FAIL read_accept: done %b cout %h expected 0 %h", mac_done, c_data_out_ext, last_c_exp);
        end
    endtask

    task automatic test_reset_mid();
        int    lat;
        bit    rs;
        host2block_val = 1'b1;
        @(posedge clk); #1;
        host2block_val = 1'b0;
        a_data_in_ext = rand_a(); b_data_in_ext = rand_b(); a_b_we_ext = 1'b1;
        @(posedge clk); #1;
        a_b_we_ext = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({mac_done, block2host_val, host2block_rdy} !== 3'b000 || c_data_out_ext !== '0) begin
            errors++;
            $display("FAIL mid_reset: flags %b cout %h expected 000 0",
                     {mac_done, block2host_val, host2block_rdy}, c_data_out_ext);
        end
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        do_op(ramp_a(), ramp_b(), lat, rs);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL post_reset_latency: got %0d expected %0d", lat, LAT);
        end
        do_read();
        last_c_exp = model(ramp_a(), ramp_b());
        checks++;
        if (c_data_out_ext !== last_c_exp) begin
            errors++;
            $display("FAIL post_reset_c: got %h expected %h", c_data_out_ext, last_c_exp);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_random();
        test_overflow();
        test_load_wait();
        test_read_handshake();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
